// File: rtl/fetch_unit.sv
// PC register and fetch stage feeding the IF/ID pipeline register.
// Handles stall, flush, branch/jump redirect and halts on a faulting fetch PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_fault,
  output logic        halted
);

  localparam logic [0:0]  ST_RUN    = 1'b0;
  localparam logic [0:0]  ST_HALT   = 1'b1;
  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic        fault_q, fault_d;

  logic        fault_now;
  logic        consume;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc_q + 32'd4;
  assign fault_now = (pc_q[1:0] != 2'b00) || (pc_q > LAST_ADDR);
  // The PC is only consumed (and may only fault) on a quiet RUN cycle.
  assign consume   = !redirect_valid && !stall && !flush && (state_q == ST_RUN);

  // PC and state next-state selection
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_valid) begin
      pc_d    = redirect_target;
      state_d = ST_RUN;
    end else if (stall) begin
      pc_d    = pc_q;
      state_d = state_q;
    end else if (state_q == ST_HALT) begin
      pc_d    = pc_q;
      state_d = ST_HALT;
    end else if (consume && fault_now) begin
      pc_d    = pc_q;
      state_d = ST_HALT;
    end else begin
      pc_d    = pc_plus4;
      state_d = ST_RUN;
    end
  end

  // IF/ID next-state selection; the memory word is dropped on a faulting PC
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    fault_d = fault_q;
    if (redirect_valid || flush || (!stall && state_q == ST_HALT)) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      ipc_d   = 32'h0000_0000;
      ipc4_d  = 32'h0000_0000;
      fault_d = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      ipc4_d  = ipc4_q;
      fault_d = fault_q;
    end else begin
      valid_d = 1'b1;
      instr_d = fault_now ? NOP_INSTR : imem_instr;
      ipc_d   = pc_q;
      ipc4_d  = pc_plus4;
      fault_d = fault_now;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= 32'h0000_0000;
      ipc4_q  <= 32'h0000_0000;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      fault_q <= fault_d;
    end
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign ifid_valid    = valid_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc       = ipc_q;
  assign ifid_pc_plus4 = ipc4_q;
  assign ifid_fault    = fault_q;
  assign halted        = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through the fetch scenarios, then
// randomized stall/flush/redirect/reset traffic checked against a behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect_valid;
  logic [31:0] redirect_target, imem_addr, imem_instr, pc;
  logic        ifid_valid, ifid_fault, halted;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [256];

  // reference model state
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
  logic        m_halt, m_valid, m_fault;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .pc(pc),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4), .ifid_fault(ifid_fault), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory model; outside the array it returns recognisable garbage
  always_comb begin
    if (imem_addr < 32'd1024) imem_instr = mem[imem_addr[9:2]];
    else                      imem_instr = 32'hBAD0_0000 ^ imem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One clock: drive inputs, advance the model by the fetch rules, compare everything
  task automatic step(input logic rs, input logic st, input logic fl,
                      input logic rv, input logic [31:0] rt);
    logic        flt, quiet;
    logic [31:0] word;
    @(negedge clk);
    reset = rs; stall = st; flush = fl; redirect_valid = rv; redirect_target = rt;
    @(posedge clk);
    #1;
    if (rs) begin
      m_pc = 32'h0; m_halt = 1'b0; m_valid = 1'b0; m_instr = 32'h0;
      m_ipc = 32'h0; m_ipc4 = 32'h0; m_fault = 1'b0;
    end else begin
      flt   = (m_pc % 4 != 0) || (m_pc > 32'd1020);
      quiet = !rv && !st && !fl && !m_halt;
      word  = mem[m_pc[9:2]];
      if (rv || fl || (!st && m_halt)) begin
        m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_fault = 1'b0;
      end else if (!st) begin
        m_valid = 1'b1; m_instr = flt ? 32'h0 : word;
        m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_fault = flt;
      end
      if (rv) begin
        m_pc = rt; m_halt = 1'b0;
      end else if (quiet && flt) begin
        m_halt = 1'b1;
      end else if (!st && !m_halt) begin
        m_pc = m_pc + 32'd4;
      end
    end
    check("pc",         pc,            m_pc);
    check("imem_addr",  imem_addr,     m_pc);
    check("halted",     {31'd0, halted},     {31'd0, m_halt});
    check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    check("ifid_instr", ifid_instr,    m_instr);
    check("ifid_pc",    ifid_pc,       m_ipc);
    check("ifid_pc4",   ifid_pc_plus4, m_ipc4);
    check("ifid_fault", {31'd0, ifid_fault}, {31'd0, m_fault});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] tgt;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h0000_0001;
    mem[0] = 32'h2008_0005; mem[1] = 32'h2009_0003; mem[2] = 32'h0109_5020;
    m_pc = 32'h0; m_halt = 1'b0; m_valid = 1'b0; m_instr = 32'h0;
    m_ipc = 32'h0; m_ipc4 = 32'h0; m_fault = 1'b0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h123);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);

    // straight-line fetch
    idle();
    check("t1_pc0", ifid_pc, 32'h0);
    check("t1_in0", ifid_instr, 32'h2008_0005);
    check("t1_p40", ifid_pc_plus4, 32'h4);
    idle();
    check("t1_in1", ifid_instr, 32'h2009_0003);
    check("t1_pc",  pc, 32'h8);

    // stall freezes PC and IF/ID
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("t2_pc", pc, 32'h8);
    check("t2_ifpc", ifid_pc, 32'h4);
    idle();
    check("t2_in2", ifid_instr, 32'h0109_5020);
    check("t2_p48", ifid_pc_plus4, 32'hC);

    // redirect beats stall and flush
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    check("t3_pc", pc, 32'h40);
    check("t3_bub", {31'd0, ifid_valid}, 32'd0);
    idle();
    check("t3_ifpc", ifid_pc, 32'h40);

    // flush alone still advances PC
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("t4_pc", pc, 32'h14);
    idle();
    check("t4_ifpc", ifid_pc, 32'h14);

    // misaligned redirect faults and halts
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h42);
    idle();
    check("t5_flt", {31'd0, ifid_fault}, 32'd1);
    check("t5_hlt", {31'd0, halted}, 32'd1);
    check("t5_ifpc", ifid_pc, 32'h42);
    for (int i = 0; i < 3; i++) idle();
    check("t5_pc", pc, 32'h42);
    check("t5_bub", {31'd0, ifid_valid}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
    idle();
    check("t5_run", {31'd0, halted}, 32'd0);
    check("t5_rpc", ifid_pc, 32'h10);

    // last legal word, then past the end
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3FC);
    idle();
    check("t6_last", {31'd0, ifid_fault}, 32'd0);
    idle();
    check("t6_oob", {31'd0, ifid_fault}, 32'd1);
    check("t6_oobi", ifid_instr, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("t6_rpc", pc, 32'h0);
    check("t6_rhlt", {31'd0, halted}, 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       tgt = {22'd0, $urandom_range(0, 255), 2'b00};
        1:       tgt = {22'd0, $urandom_range(240, 263), 2'b00};
        2:       tgt = $urandom_range(0, 1100);
        default: tgt = $urandom;
      endcase
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 1, $urandom_range(0, 19) < 1, tgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
PC and fetch stage that sits directly upstream of the instruction memory. It drives the byte address into the memory and receives the big-endian 32-bit word the memory returns combinationally in the same cycle. It captures that word into the IF/ID pipeline register for the decoder. It also handles stall, flush, branch/jump redirect, and fetch faults (misaligned or out-of-range PC).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_BYTES, 1024, instruction memory size in bytes; last legal fetch address is IMEM_BYTES-4
NOP_INSTR, 32'h0000_0000, encoding inserted for bubbles and faulting fetches (MIPS sll $0,$0,0)

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard stall from decode; freezes PC and IF/ID
flush  in  1  squash IF/ID contents (bubble) without redirecting PC
redirect_valid  in  1  branch/jump taken; load redirect_target into PC
redirect_target  in  32  byte address of new fetch point
imem_addr  out  32  byte address to instruction memory (= pc, combinational)
imem_instr  in  32  instruction word returned by memory for imem_addr, same cycle
pc  out  32  current fetch PC
ifid_valid  out  1  IF/ID holds a real instruction
ifid_instr  out  32  registered instruction
ifid_pc  out  32  address of ifid_instr
ifid_pc_plus4  out  32  ifid_pc + 4, mod 2^32
ifid_fault  out  1  registered entry came from a faulting PC
halted  out  1  fetch halted after a fault (state == HALT)

Behaviour:
- Decided: one clock `clk`; `reset` synchronous, active-high.
- Reset values: pc = RESET_PC; state = RUN; halted = 0; ifid_valid = 0; ifid_instr = NOP_INSTR; ifid_pc = 0; ifid_pc_plus4 = 0; ifid_fault = 0.
- Reset takes priority over every other input, in any state and mid-stall.
- imem_addr = pc, purely combinational. Fetch latency: the word at pc appears on ifid_* after one rising edge.
- fault_now = (pc[1:0] != 0) OR (pc > IMEM_BYTES-4), evaluated as an unsigned 32-bit compare.
- PC next-state priority: reset > redirect_valid > stall > (state == HALT) > pc + 4.
  - redirect_valid overrides stall.
  - pc + 4 wraps modulo 2^32.
  - When redirect_valid is high, redirect_target is loaded unmodified, even if misaligned.
- IF/ID next-state priority: reset > (redirect_valid OR flush) > stall > state-based load.
  - Bubble = valid 0, instr NOP_INSTR, fault 0, pc/pc_plus4 cleared to 0.
  - flush overrides stall.
- State machine:
  - RUN, no stall/flush/redirect:
    - fault_now = 0: IF/ID loads {valid 1, imem_instr, pc, pc+4, fault 0}; stay in RUN.
    - fault_now = 1: IF/ID loads {valid 1, NOP_INSTR, pc, pc+4, fault 1}; go to HALT; pc holds.
  - HALT:
    - pc holds and halted = 1.
    - IF/ID loads a bubble each unstalled cycle.
    - redirect_valid returns to RUN with pc = redirect_target.
    - stall and flush alone do not leave HALT.
  - Any state with redirect_valid: next state RUN.
- A fault is never raised while stall, flush or redirect_valid is high; the fault is evaluated on the first cycle the PC is actually consumed.
- imem_instr is ignored whenever fault_now = 1, so out-of-range memory contents never reach decode.
- No internal combinational path from imem_instr to any output.

Test Plan:
1. Memory holds 0x20080005, 0x20090003, 0x01095020 at 0x0/0x4/0x8; release reset → next three edges give ifid_pc 0x0/0x4/0x8, ifid_instr matching, valid 1, pc_plus4 0x4/0x8/0xC.
2. Assert stall for 2 cycles while pc = 0x8 → pc and ifid_* (pc 0x4) frozen both cycles; on release, ifid_pc = 0x8 then 0xC.
3. redirect_valid with target 0x40, stall and flush simultaneously high at pc 0xC → next edge pc = 0x40, ifid_valid 0, ifid_instr 0; following edge ifid_pc = 0x40, valid 1.
4. flush alone at pc 0x10 → ifid bubble; pc advances to 0x14; next edge ifid_pc = 0x14.
5. Redirect to 0x42 → next edge ifid_fault 1, ifid_instr 0, ifid_pc 0x42, halted 1; pc stays 0x42 and ifid_valid 0 for 3 further cycles. Redirect to 0x10 → halted 0, ifid_pc = 0x10 valid.
6. Redirect to 0x3FC → 0x3FC fetched valid with fault 0; next fetch 0x400 gives fault 1 and HALT. Assert reset while halted → pc = 0x0, halted 0, ifid_valid 0 on the next edge.
